anita_multi_event_buffer: RTL and testbench

//  Parametrised N-deep event buffer ring for the TURF readout path; successor to the two-buffer scheme.

---
 rtl/anita_multi_event_buffer_pkg.sv | 22 ++
 rtl/anita_evbuf_ram.sv | 35 +++
 rtl/anita_multi_event_buffer.sv | 139 +++++++++++++
 tb/tb_anita_multi_event_buffer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/anita_multi_event_buffer_pkg.sv
// anita_multi_event_buffer_pkg: shared constants and types for the multi-event buffer ring
package anita_multi_event_buffer_pkg;
   localparam int OVF_W            = 8;
   localparam int FIELD_W          = 8;
   localparam int RDP_W            = 3;
   localparam int ST_OVF_LSB       = 24;
   localparam int ST_OCC_LSB       = 16;
   localparam int ST_ACT_LSB       = 8;
   localparam int ST_RDP_LSB       = 4;
   localparam int ST_FULL          = 3;
   localparam int ST_EMPTY         = 2;
   localparam int ST_RDACT         = 1;
   localparam int ST_PEND          = 0;
   localparam int CLR_MODE_SINGLE  = 0;
   localparam int CLR_MODE_CONFIRM = 1;

   typedef enum logic {CLR_IDLE = 1'b0, CLR_PENDING = 1'b1} clr_state_t;

   function automatic logic [OVF_W-1:0] sat_inc(input logic [OVF_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction
endpackage

// File: rtl/anita_evbuf_ram.sv
// anita_evbuf_ram: even/odd DW-wide simple dual-port banks presenting 2*DW-bit registered reads
module anita_evbuf_ram #(
   parameter int NBUF  = 4,
   parameter int WR_AW = 6,
   parameter int DW    = 16
)(
   input  logic                            i_clk,
   input  logic                            i_we,
   input  logic                            i_sel,
   input  logic [$clog2(NBUF)+WR_AW-2:0]   i_wa,
   input  logic [DW-1:0]                   i_wd,
   input  logic [$clog2(NBUF)+WR_AW-2:0]   i_ra,
   output logic [2*DW-1:0]                 o_rd
);
   localparam int DEPTH = NBUF * (2 ** (WR_AW - 1));

   logic [DW-1:0] r_even [DEPTH];
   logic [DW-1:0] r_odd  [DEPTH];
   logic [DW-1:0] r_rd_even;
   logic [DW-1:0] r_rd_odd;

   // even bank: written when the word address is even, read every cycle
   always_ff @(posedge i_clk) begin
      if (i_we && !i_sel) r_even[i_wa] <= i_wd;
      r_rd_even <= r_even[i_ra];
   end

   // odd bank: written when the word address is odd, read every cycle
   always_ff @(posedge i_clk) begin
      if (i_we && i_sel) r_odd[i_wa] <= i_wd;
      r_rd_odd <= r_odd[i_ra];
   end

   assign o_rd = {r_rd_odd, r_rd_even};
endmodule

// File: rtl/anita_multi_event_buffer.sv
// anita_multi_event_buffer: N-deep event buffer ring with occupancy tracking and host clear handshake
module anita_multi_event_buffer
   import anita_multi_event_buffer_pkg::*;
#(
   parameter int NBUF          = 4,
   parameter int WR_AW         = 6,
   parameter int DW            = 16,
   parameter int CLEAR_CONFIRM = CLR_MODE_CONFIRM
)(
   input  logic                     clk33_i,
   input  logic                     rst_n_i,
   input  logic [WR_AW-1:0]         event_wr_addr_i,
   input  logic [DW-1:0]            event_wr_dat_i,
   input  logic                     event_wr_i,
   input  logic                     event_done_i,
   input  logic [WR_AW-2:0]         event_rd_addr_i,
   output logic [2*DW-1:0]          event_rd_dat_o,
   input  logic                     clear_evt_i,
   output logic                     clear_evt_o,
   output logic [$clog2(NBUF)-1:0]  read_buffer_o,
   output logic [$clog2(NBUF)-1:0]  write_buffer_o,
   output logic [NBUF-1:0]          buffer_active_o,
   output logic [$clog2(NBUF):0]    occupancy_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [OVF_W-1:0]         overflow_cnt_o,
   output logic [31:0]              status_o
);
   localparam int         PW       = $clog2(NBUF);
   localparam logic [PW:0] OCC_FULL = (PW+1)'(NBUF);
   localparam logic       CONFIRM  = (CLEAR_CONFIRM != CLR_MODE_SINGLE);

   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [PW-1:0]    r_rd_buf;
   logic [NBUF-1:0]  r_active;
   logic [PW:0]      r_occ;
   logic [OVF_W-1:0] r_ovf;
   logic             r_clr_evt;
   logic             r_clear_go;
   clr_state_t       r_state;
   clr_state_t       w_state_nxt;
   logic             w_go_nxt;
   logic             w_pend;
   logic             w_full;
   logic             w_empty;
   logic             w_wr_en;
   logic             w_done_ok;
   logic             w_rel;
   logic [NBUF-1:0]  w_active_nxt;
   logic [31:0]      w_status;

   // ring flags from the pre-edge occupancy and the per-edge accept/release decisions
   always_comb begin
      w_full       = (r_occ == OCC_FULL);
      w_empty      = (r_occ == '0);
      w_wr_en      = event_wr_i && !w_full;
      w_done_ok    = event_done_i && !w_full;
      w_rel        = r_clear_go && r_active[r_rd_ptr];
      w_active_nxt = (r_active | (NBUF'(w_done_ok) << r_wr_ptr)) & ~(NBUF'(w_rel) << r_rd_ptr);
   end

   // ring pointers, ownership flags, occupancy and overflow count
   always_ff @(posedge clk33_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_rd_buf  <= '0;
         r_active  <= '0;
         r_occ     <= '0;
         r_ovf     <= '0;
         r_clr_evt <= 1'b0;
      end else begin
         r_wr_ptr  <= r_wr_ptr + PW'(w_done_ok);
         r_rd_ptr  <= r_rd_ptr + PW'(w_rel);
         r_rd_buf  <= r_rd_ptr;
         r_active  <= w_active_nxt;
         r_occ     <= r_occ + (PW+1)'(w_done_ok) - (PW+1)'(w_rel);
         r_clr_evt <= w_rel;
         if (event_done_i && w_full) r_ovf <= sat_inc(r_ovf);
      end
   end

   // clear handshake state and the one-cycle release request
   always_ff @(posedge clk33_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state    <= CLR_IDLE;
         r_clear_go <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_clear_go <= w_go_nxt;
      end
   end

   // next clear state: in confirm mode a pulse arms and the following pulse confirms
   always_comb begin
      w_state_nxt = r_state;
      if (CONFIRM && clear_evt_i) w_state_nxt = (r_state == CLR_IDLE) ? CLR_PENDING : CLR_IDLE;
   end

   // clear outputs: release request and the armed flag
   always_comb begin
      w_go_nxt = clear_evt_i && (!CONFIRM || r_state == CLR_PENDING);
      w_pend   = (r_state == CLR_PENDING);
   end

   // status word packing
   always_comb begin
      w_status                          = '0;
      w_status[ST_OVF_LSB +: OVF_W]     = r_ovf;
      w_status[ST_OCC_LSB +: FIELD_W]   = FIELD_W'(r_occ);
      w_status[ST_ACT_LSB +: FIELD_W]   = FIELD_W'(r_active);
      w_status[ST_RDP_LSB +: RDP_W]     = RDP_W'(r_rd_ptr);
      w_status[ST_FULL]                 = w_full;
      w_status[ST_EMPTY]                = w_empty;
      w_status[ST_RDACT]                = r_active[r_rd_ptr];
      w_status[ST_PEND]                 = w_pend;
   end

   anita_evbuf_ram #(.NBUF(NBUF), .WR_AW(WR_AW), .DW(DW)) u_ram (
      .i_clk (clk33_i),
      .i_we  (w_wr_en),
      .i_sel (event_wr_addr_i[0]),
      .i_wa  ({r_wr_ptr, event_wr_addr_i[WR_AW-1:1]}),
      .i_wd  (event_wr_dat_i),
      .i_ra  ({r_rd_ptr, event_rd_addr_i}),
      .o_rd  (event_rd_dat_o)
   );

   assign clear_evt_o     = r_clr_evt;
   assign read_buffer_o   = r_rd_buf;
   assign write_buffer_o  = r_wr_ptr;
   assign buffer_active_o = r_active;
   assign occupancy_o     = r_occ;
   assign full_o          = w_full;
   assign empty_o         = w_empty;
   assign overflow_cnt_o  = r_ovf;
   assign status_o        = w_status;
endmodule

// File: tb/tb_anita_multi_event_buffer.sv
// tb_anita_multi_event_buffer: directed and randomized checks against a queue-based ring model
module tb_anita_multi_event_buffer;
   localparam int NB = 4;

   logic        clk = 0;
   logic        rst_n = 0;
   logic [5:0]  wr_addr = 0;
   logic [15:0] wr_dat = 0;
   logic        ev_wr = 0;
   logic        ev_done = 0;
   logic [4:0]  rd_addr = 0;
   logic        clr = 0;
   logic [31:0] rd_dat;
   logic        cev;
   logic [1:0]  rdbuf_o, wrbuf_o;
   logic [3:0]  active_o;
   logic [2:0]  occ_o;
   logic        full_o, empty_o;
   logic [7:0]  ovf_o;
   logic [31:0] status_o;

   logic        c0_rst_n = 0;
   logic        c0_done = 0;
   logic        c0_clr = 0;
   logic [31:0] c0_rd_dat;
   logic        c0_cev;
   logic [1:0]  c0_rdbuf, c0_wrbuf;
   logic [3:0]  c0_active;
   logic [2:0]  c0_occ;
   logic        c0_full, c0_empty;
   logic [7:0]  c0_ovf;
   logic [31:0] c0_status;

   int errors = 0;
   int checks = 0;

   int          q[$];
   int          m_wr, m_rd, m_rdbuf, m_ovf;
   bit          m_pend, m_go, m_cev;
   logic [15:0] mem [NB][64];
   bit          vld [NB][64];
   logic [31:0] exp_rd;
   bit          exp_rd_v;

   always #15 clk = ~clk;

   anita_multi_event_buffer #(.NBUF(4), .WR_AW(6), .DW(16), .CLEAR_CONFIRM(1)) dut (
      .clk33_i(clk), .rst_n_i(rst_n), .event_wr_addr_i(wr_addr), .event_wr_dat_i(wr_dat),
      .event_wr_i(ev_wr), .event_done_i(ev_done), .event_rd_addr_i(rd_addr), .event_rd_dat_o(rd_dat),
      .clear_evt_i(clr), .clear_evt_o(cev), .read_buffer_o(rdbuf_o), .write_buffer_o(wrbuf_o),
      .buffer_active_o(active_o), .occupancy_o(occ_o), .full_o(full_o), .empty_o(empty_o),
      .overflow_cnt_o(ovf_o), .status_o(status_o));

   anita_multi_event_buffer #(.NBUF(4), .WR_AW(6), .DW(16), .CLEAR_CONFIRM(0)) dut0 (
      .clk33_i(clk), .rst_n_i(c0_rst_n), .event_wr_addr_i(6'd0), .event_wr_dat_i(16'd0),
      .event_wr_i(1'b0), .event_done_i(c0_done), .event_rd_addr_i(5'd0), .event_rd_dat_o(c0_rd_dat),
      .clear_evt_i(c0_clr), .clear_evt_o(c0_cev), .read_buffer_o(c0_rdbuf), .write_buffer_o(c0_wrbuf),
      .buffer_active_o(c0_active), .occupancy_o(c0_occ), .full_o(c0_full), .empty_o(c0_empty),
      .overflow_cnt_o(c0_ovf), .status_o(c0_status));

   task automatic chk(input string t, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", t, obs, exp);
      end
   endtask

   task automatic check_all(input string t);
      logic [7:0]  am;
      logic [31:0] st;
      int          occ;
      am  = '0;
      occ = q.size();
      foreach (q[i]) am[q[i]] = 1'b1;
      st = {8'(m_ovf), 8'(occ), am, 1'b0, 3'(m_rd), occ == NB, occ == 0, am[m_rd], m_pend};
      chk({t, ".occ"}, 32'(occ_o), 32'(occ));
      chk({t, ".full"}, 32'(full_o), 32'(occ == NB));
      chk({t, ".empty"}, 32'(empty_o), 32'(occ == 0));
      chk({t, ".active"}, 32'(active_o), 32'(am));
      chk({t, ".wrbuf"}, 32'(wrbuf_o), 32'(m_wr));
      chk({t, ".rdbuf"}, 32'(rdbuf_o), 32'(m_rdbuf));
      chk({t, ".ovf"}, 32'(ovf_o), 32'(m_ovf));
      chk({t, ".cev"}, 32'(cev), 32'(m_cev));
      chk({t, ".status"}, status_o, st);
      if (exp_rd_v) chk({t, ".rd_dat"}, rd_dat, exp_rd);
   endtask

   task automatic tick();
      bit full;
      bit rel;
      bit go_n;
      int ra;
      full = (q.size() == NB);
      rel  = m_go && (q.size() > 0);
      go_n = 0;
      ra   = int'(rd_addr);
      exp_rd   = {mem[m_rd][2*ra+1], mem[m_rd][2*ra]};
      exp_rd_v = vld[m_rd][2*ra+1] && vld[m_rd][2*ra];
      if (ev_wr && !full) begin
         mem[m_wr][wr_addr] = wr_dat;
         vld[m_wr][wr_addr] = 1;
      end
      m_rdbuf = m_rd;
      if (rel) begin
         void'(q.pop_front());
         m_rd = (m_rd + 1) % NB;
      end
      m_cev = rel;
      if (ev_done) begin
         if (!full) begin
            q.push_back(m_wr);
            m_wr = (m_wr + 1) % NB;
         end else if (m_ovf < 255) m_ovf++;
      end
      if (clr) begin
         if (m_pend) begin
            m_pend = 0;
            go_n = 1;
         end else m_pend = 1;
      end
      m_go = go_n;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      ev_wr = 0; ev_done = 0; clr = 0; rst_n = 0;
      q.delete();
      m_wr = 0; m_rd = 0; m_rdbuf = 0; m_ovf = 0;
      m_pend = 0; m_go = 0; m_cev = 0; exp_rd_v = 0;
      @(posedge clk);
      #1;
      rst_n = 1;
   endtask

   task automatic pulse_done();
      ev_done = 1; tick(); ev_done = 0;
   endtask

   task automatic pulse_clr();
      clr = 1; tick(); clr = 0;
   endtask

   initial begin
      #1;
      do_reset();
      c0_rst_n = 1;
      check_all("reset");
      chk("reset.status_const", status_o, 32'h0000_0004);

      for (int i = 0; i < 4; i++) begin
         ev_wr = 1; wr_addr = 6'($urandom); wr_dat = 16'($urandom); tick(); ev_wr = 0;
         pulse_done();
      end
      check_all("fill4");
      chk("fill4.full", 32'(full_o), 1);
      chk("fill4.occ", 32'(occ_o), 4);
      chk("fill4.active", 32'(active_o), 32'hF);
      chk("fill4.wrbuf", 32'(wrbuf_o), 0);

      do_reset();
      ev_wr = 1; wr_addr = 2; wr_dat = 16'hA5A5; tick();
      wr_addr = 3; wr_dat = 16'h5A5A; tick();
      ev_wr = 0; rd_addr = 1; tick();
      chk("read.pair", rd_dat, 32'h5A5A_A5A5);
      check_all("read");

      do_reset();
      pulse_done();
      pulse_done();
      pulse_clr();
      chk("arm.pending", 32'(status_o[0]), 1);
      check_all("arm");
      tick();
      chk("arm.hold_occ", 32'(occ_o), 2);
      check_all("arm_hold");
      pulse_clr();
      check_all("confirm");
      tick();
      chk("release.cev", 32'(cev), 1);
      chk("release.occ", 32'(occ_o), 1);
      check_all("release");
      tick();
      chk("release.cev_off", 32'(cev), 0);
      chk("release.rdbuf", 32'(rdbuf_o), 1);
      check_all("release_after");

      do_reset();
      for (int i = 0; i < 4; i++) pulse_done();
      pulse_done();
      chk("drop.ovf", 32'(ovf_o), 1);
      chk("drop.wrbuf", 32'(wrbuf_o), 0);
      check_all("drop");
      ev_done = 1;
      for (int i = 0; i < 260; i++) tick();
      ev_done = 0;
      chk("sat.ovf", 32'(ovf_o), 255);
      check_all("sat");
      pulse_clr();
      pulse_clr();
      ev_done = 1; tick(); ev_done = 0;
      chk("race.occ", 32'(occ_o), 3);
      chk("race.wrbuf", 32'(wrbuf_o), 0);
      check_all("race");

      c0_clr = 1; @(posedge clk); #1; c0_clr = 0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("c0_empty.cev", 32'(c0_cev), 0);
      end
      chk("c0_empty.rdbuf", 32'(c0_rdbuf), 0);
      chk("c0_empty.empty", 32'(c0_empty), 1);
      chk("c0_empty.status", c0_status, 32'h0000_0004);
      c0_done = 1; @(posedge clk); #1; c0_done = 0;
      c0_clr = 1; @(posedge clk); #1; c0_clr = 0;
      chk("c0_go.cev", 32'(c0_cev), 0);
      @(posedge clk); #1;
      chk("c0_rel.cev", 32'(c0_cev), 1);
      chk("c0_rel.occ", 32'(c0_occ), 0);
      chk("c0_rel.wrbuf", 32'(c0_wrbuf), 1);
      chk("c0_rel.active", 32'(c0_active), 0);
      chk("c0_rel.full", 32'(c0_full), 0);
      chk("c0_rel.ovf", 32'(c0_ovf), 0);
      chk("c0_rel.status", c0_status, 32'h0000_0014);

      do_reset();
      for (int i = 0; i < 3; i++) pulse_done();
      check_all("pre_async");
      ev_wr = 1; wr_addr = 5; wr_dat = 16'($urandom);
      #5;
      rst_n = 0;
      ev_wr = 0;
      #1;
      chk("async.occ", 32'(occ_o), 0);
      chk("async.active", 32'(active_o), 0);
      chk("async.empty", 32'(empty_o), 1);
      chk("async.full", 32'(full_o), 0);
      chk("async.wrbuf", 32'(wrbuf_o), 0);
      chk("async.rdbuf", 32'(rdbuf_o), 0);
      chk("async.status", status_o, 32'h0000_0004);
      do_reset();
      pulse_done();
      chk("post_async.active", 32'(active_o), 1);
      check_all("post_async");

      do_reset();
      for (int i = 0; i < 500; i++) begin
         ev_wr   = 1'($urandom);
         wr_addr = 6'($urandom);
         wr_dat  = 16'($urandom);
         rd_addr = 5'($urandom);
         ev_done = (i < 250) ? ($urandom_range(3) == 0) : ($urandom_range(7) == 0);
         clr     = (i < 250) ? ($urandom_range(2) == 0) : ($urandom_range(1) == 0);
         tick();
         check_all("rand");
      end
      ev_wr = 0; ev_done = 0; clr = 0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
